// File: rtl/my_isolation_ctrl.sv
// Operand-isolation sequencer: wakes the functional unit on demand, holds off ready
// through a settling window, re-isolates after an idle run or on a forced request.
module my_isolation_ctrl #(
  parameter int WAKE_CYCLES  = 2,
  parameter int IDLE_TIMEOUT = 8,
  parameter int CNT_WIDTH    = 4,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iOp_Valid,
  input  logic                  iForce_Isolate,
  input  logic                  iStat_Clear,
  output logic                  oOp_Ready,
  output logic                  oIsolation_Signal,
  output logic [1:0]            oState,
  output logic [STAT_WIDTH-1:0] oIso_Cycles
);

  typedef enum logic [1:0] {
    ISO    = 2'b00,
    WAKE   = 2'b01,
    ACTIVE = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0] WAKE_LAST = CNT_WIDTH'(WAKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(IDLE_TIMEOUT - 1);

  state_t                state;
  logic [CNT_WIDTH-1:0]  wake_cnt;
  logic [CNT_WIDTH-1:0]  idle_cnt;
  logic [STAT_WIDTH-1:0] iso_cycles;
  logic                  pass_en;
  logic                  ready;

  // Outputs are updated together with the state so pass/ready never disagree with it.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state      <= ISO;
      wake_cnt   <= '0;
      idle_cnt   <= '0;
      iso_cycles <= '0;
      pass_en    <= 1'b0;
      ready      <= 1'b0;
    end else begin
      if (iStat_Clear)
        iso_cycles <= '0;
      else if (state == ISO && iso_cycles != '1)
        iso_cycles <= iso_cycles + 1'b1;

      if (iForce_Isolate) begin
        state   <= ISO;
        pass_en <= 1'b0;
        ready   <= 1'b0;
      end else begin
        case (state)
          ISO: begin
            if (iOp_Valid) begin
              state    <= WAKE;
              wake_cnt <= '0;
              pass_en  <= 1'b1;
            end
          end
          WAKE: begin
            wake_cnt <= wake_cnt + 1'b1;
            if (wake_cnt == WAKE_LAST) begin
              state    <= ACTIVE;
              idle_cnt <= '0;
              ready    <= 1'b1;
            end
          end
          ACTIVE: begin
            // A request on the timeout edge keeps the unit awake.
            if (iOp_Valid) begin
              idle_cnt <= '0;
            end else if (idle_cnt == IDLE_LAST) begin
              state   <= ISO;
              pass_en <= 1'b0;
              ready   <= 1'b0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          default: begin
            state   <= ISO;
            pass_en <= 1'b0;
            ready   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oState            = state;
  assign oIsolation_Signal = pass_en;
  assign oOp_Ready         = ready;
  assign oIso_Cycles       = iso_cycles;

endmodule

// File: tb/tb_my_isolation_ctrl.sv
// Self-checking bench for my_isolation_ctrl: edge-indexed behavioural model compared
// every cycle, plus directed literal checks at the interesting points.
module tb_my_isolation_ctrl;

  localparam int WAKE   = 2;
  localparam int IDLE   = 8;
  localparam int STAT_W = 4;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic              iClk;
  logic              iReset_n;
  logic              iOp_Valid;
  logic              iForce_Isolate;
  logic              iStat_Clear;
  logic              oOp_Ready;
  logic              oIsolation_Signal;
  logic [1:0]        oState;
  logic [STAT_W-1:0] oIso_Cycles;

  int errors = 0;
  int checks = 0;

  my_isolation_ctrl #(
    .WAKE_CYCLES (WAKE),
    .IDLE_TIMEOUT(IDLE),
    .CNT_WIDTH   (4),
    .STAT_WIDTH  (STAT_W)
  ) dut (
    .iClk             (iClk),
    .iReset_n         (iReset_n),
    .iOp_Valid        (iOp_Valid),
    .iForce_Isolate   (iForce_Isolate),
    .iStat_Clear      (iStat_Clear),
    .oOp_Ready        (oOp_Ready),
    .oIsolation_Signal(oIsolation_Signal),
    .oState           (oState),
    .oIso_Cycles      (oIso_Cycles)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Model: mode 0/1/2 = isolated/waking/active, timing taken from absolute edge indices.
  int m_mode      = 0;
  int m_edge      = 0;
  int m_wake_from = 0;
  int m_last_busy = 0;
  int m_iso       = 0;

  function automatic void modelReset();
    m_mode = 0;
    m_iso  = 0;
  endfunction

  function automatic void modelEdge(input logic v, input logic f, input logic c);
    m_edge++;
    if (c) m_iso = 0;
    else if (m_mode == 0) m_iso = (m_iso + 1 > STAT_MAX) ? STAT_MAX : m_iso + 1;
    if (f) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (v) begin
        m_mode      = 1;
        m_wake_from = m_edge;
      end
    end else if (m_mode == 1) begin
      if (m_edge - m_wake_from == WAKE) begin
        m_mode      = 2;
        m_last_busy = m_edge;
      end
    end else begin
      if (v) m_last_busy = m_edge;
      else if (m_edge - m_last_busy == IDLE) m_mode = 0;
    end
  endfunction

  task automatic compareOne(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) modelReset();
    else modelEdge(iOp_Valid, iForce_Isolate, iStat_Clear);
    #1;
    if ($time > 2) begin
      compareOne("model_state", int'(oState), m_mode);
      compareOne("model_pass", int'(oIsolation_Signal), (m_mode != 0) ? 1 : 0);
      compareOne("model_ready", int'(oOp_Ready), (m_mode == 2) ? 1 : 0);
      compareOne("model_iso_cycles", int'(oIso_Cycles), m_iso);
    end
  end

  // Drive inputs right after a falling edge and let n rising edges pass.
  task automatic applyStimulus(input logic v, input logic f, input logic c, input int n);
    iOp_Valid      = v;
    iForce_Isolate = f;
    iStat_Clear    = c;
    repeat (n) @(negedge iClk);
  endtask

  task automatic checkOutput(input string name, input int st, input int cyc);
    compareOne({name, "_state"}, int'(oState), st);
    compareOne({name, "_pass"}, int'(oIsolation_Signal), (st != 0) ? 1 : 0);
    compareOne({name, "_ready"}, int'(oOp_Ready), (st == 2) ? 1 : 0);
    if (cyc >= 0) compareOne({name, "_iso_cycles"}, int'(oIso_Cycles), cyc);
  endtask

  initial begin
    iReset_n       = 1'b0;
    iOp_Valid      = 1'b0;
    iForce_Isolate = 1'b0;
    iStat_Clear    = 1'b0;
    repeat (2) @(negedge iClk);
    checkOutput("reset", 0, 0);
    iReset_n = 1'b1;

    applyStimulus(0, 0, 0, 5);
    checkOutput("idle5", 0, 5);

    applyStimulus(1, 0, 0, 1);
    checkOutput("wake_first", 1, 6);
    applyStimulus(1, 0, 0, 1);
    checkOutput("wake_second", 1, 6);
    applyStimulus(1, 0, 0, 1);
    checkOutput("active_ready", 2, 6);

    applyStimulus(1, 0, 0, 2);
    applyStimulus(0, 0, 0, 7);
    checkOutput("idle7_active", 2, -1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("idle8_iso", 0, -1);

    applyStimulus(1, 0, 0, 4);
    applyStimulus(0, 0, 0, 6);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("pulse_active", 2, -1);
    applyStimulus(0, 0, 0, 6);
    checkOutput("pulse_idle7", 2, -1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("pulse_iso", 0, -1);

    applyStimulus(1, 0, 0, 1);
    checkOutput("force_pre_wake", 1, -1);
    applyStimulus(1, 1, 0, 1);
    checkOutput("force_wake_iso", 0, -1);
    applyStimulus(1, 1, 0, 3);
    checkOutput("force_held", 0, -1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("release_wake", 1, -1);
    applyStimulus(1, 0, 0, 2);
    checkOutput("release_active", 2, -1);
    applyStimulus(1, 1, 0, 1);
    checkOutput("force_active_iso", 0, -1);

    applyStimulus(0, 0, 1, 1);
    checkOutput("stat_clear0", 0, 0);
    applyStimulus(0, 0, 0, 10);
    checkOutput("stat_ten", 0, 10);
    applyStimulus(0, 0, 0, 10);
    checkOutput("stat_saturated", 0, 15);
    applyStimulus(0, 0, 1, 1);
    checkOutput("stat_clear1", 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("stat_restart", 0, 1);

    applyStimulus(1, 0, 0, 3);
    checkOutput("pre_reset_active", 2, -1);
    #2;
    iReset_n = 1'b0;
    #1;
    checkOutput("async_reset", 0, 0);
    @(negedge iClk);
    iReset_n = 1'b1;
    applyStimulus(1, 0, 0, 1);
    checkOutput("post_reset_wake", 1, 1);
    applyStimulus(0, 0, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
